rpl_match_engine: RTL and testbench
===================================

# rpl_match_engine

Hardware byte-code executor for a subset of the RPL matching VM: it fetches single-word instructions from an external code ROM, matches them against an external input buffer, and backtracks through an internal, parametrised stack. It replaces software matching for hot patterns and adds what the software VM lacks: a bounded stack with error reporting instead of panics, multiple charset slots loaded at run time, and a stack high-water mark. It sits between the code/input memories and the host's match-request logic.

## Interface
- PC_W, 12, code address width; pc arithmetic wraps modulo 2^PC_W
- POS_W, 16, input position width
- BT_DEPTH, 32, backtrack stack entries (power of two, ≥2)
- NUM_SETS, 8, charset slots of 256 bits each
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle run request; ignored while busy
- start_pc  in  PC_W  first instruction; start_pos  in  POS_W  first input index; in_len  in  POS_W  input length (sampled on start)
- busy  out  1  run in progress; done  out  1  one-cycle pulse at run end
- matched  out  1  result; match_end  out  POS_W  end position (start_pos on no-match/error)
- err  out  2  0 none, 1 stack overflow, 2 illegal opcode, 3 stack underflow
- bt_max  out  $clog2(BT_DEPTH)+1  stack high-water mark of last run
- code_addr  out  PC_W; code_data  in  32  (data valid cycle after address)
- in_addr  out  POS_W; in_data  in  8  (data valid cycle after address)
- cs_we  in  1; cs_sel  in  $clog2(NUM_SETS); cs_word  in  3; cs_wdata  in  32  charset load, 32 bits per write, bit n = byte value cs_word*32+n; ignored while busy

## Operation
- Instruction word: [31:24] opcode, [23:8] signed 16-bit relative offset (sign-extended/truncated to PC_W), [7:0] char or set index. "ok" = pos<len and byte matches.
- 0x00 char c: ok → pos++,pc++; else fail. 0x01 any. 0x02 set k.
- 0x03 test_char / 0x04 test_set: ok → pc++ (no consume); else pc+=off.
- 0x05 choice: push {pc+off,pos}; pc++. Full stack → err=1.
- 0x06 commit: pop; pc+=off. 0x07 partial_commit: top.pos=pos; pc+=off. 0x08 back_commit: pop into pos; pc+=off. Empty stack on 06–08 → err=3.
- 0x09 jmp: pc+=off. 0x0A fail. 0x0B fail_twice: pop then fail (empty → err=3).
- 0x0C span k, 0x0D until_char c: see Configuration.
- 0x0E end: matched=1, match_end=pos; leftover stack entries discarded.
- Any other opcode → err=2.
- fail: stack non-empty → pop, pc/pos restored; empty → done, matched=0, err=0.
- Errors end the run: done, matched=0, match_end=start_pos.
- FSM: IDLE → FETCH (drive code_addr=pc, in_addr=pos) → EXEC (decode, compare, update) → FETCH | SCAN | DONE → IDLE. SCAN loops for span/until_char.
- Stack pointer and bt_max cleared on start; bt_max updated on every push.

## Timing
- Reset: busy=0, done=0, matched=0, match_end=0, err=0, bt_max=0, code_addr=0, in_addr=0, stack empty, all charset bits 0, FSM IDLE.
- start accepted in IDLE → busy=1 next cycle; FETCH that cycle.
- Every non-scan instruction: 2 cycles (FETCH+EXEC). Fail-pop happens in EXEC; next cycle is FETCH at restored pc.
- SCAN: 2 cycles per consumed byte, 2 cycles to leave (terminating byte or pos=len).
- done high for exactly one cycle, the cycle busy falls; matched/match_end/err/bt_max hold until next start.
- Charset write and start on the same cycle: write lands before the run uses it.
- rst mid-run: immediate return to reset state, no done pulse.

## Configuration
- RPL_SPAN_EN defined: 0x0C span k consumes while set k matches; 0x0D until_char consumes while byte≠c; both stop at len, pc++, never fail.
- Undefined: SCAN state and logic absent; 0x0C/0x0D decode as illegal (err=2).

## Test plan
- Program char'a',char'b',char'c',end; input "abcd", start_pos=0 → matched=1, match_end=3, err=0, done 8 cycles after busy rises.
- 0:choice +3, 1:char'x', 2:commit +2, 3:char'a', 4:end; input "ab" → matched=1, match_end=1, bt_max=1.
- BT_DEPTH=4; 0:choice +1, 1:jmp −1 → fifth choice gives err=1, matched=0, bt_max=4.
- Set 0=[0-9]; 0:span 0, 1:end; input "123x" → with RPL_SPAN_EN match_end=3; without, err=2.
- char'z' on "a" → done, matched=0, err=0, match_end=0; commit on empty stack → err=3.
- Assert rst during SCAN → all outputs zero next cycle, no done; subsequent run of first scenario passes.

Source files
------------

// File: rtl/rpl_match_engine.sv
// rpl_match_engine: hardware executor for a subset of the RPL matching VM.
// It fetches one instruction word per step from an external code ROM and
// reads one input byte per step from an external buffer. Both memories return
// data one cycle after the address is driven. Backtracking uses an internal
// stack of {pc, pos} pairs that is BT_DEPTH entries deep.
// Optional feature macro: RPL_SPAN_EN enables the span/until_char scan
// instructions and the SCAN state. When it is undefined, opcodes 0x0C and
// 0x0D decode as illegal.
module rpl_match_engine #(
  parameter int PC_W     = 12,
  parameter int POS_W    = 16,
  parameter int BT_DEPTH = 32,
  parameter int NUM_SETS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [PC_W-1:0]             start_pc,
  input  logic [POS_W-1:0]            start_pos,
  input  logic [POS_W-1:0]            in_len,
  output logic                        busy,
  output logic                        done,
  output logic                        matched,
  output logic [POS_W-1:0]            match_end,
  output logic [1:0]                  err,
  output logic [$clog2(BT_DEPTH):0]   bt_max,
  output logic [PC_W-1:0]             code_addr,
  input  logic [31:0]                 code_data,
  output logic [POS_W-1:0]            in_addr,
  input  logic [7:0]                  in_data,
  input  logic                        cs_we,
  input  logic [$clog2(NUM_SETS)-1:0] cs_sel,
  input  logic [2:0]                  cs_word,
  input  logic [31:0]                 cs_wdata
);

  localparam int AW  = $clog2(BT_DEPTH);
  localparam int SPW = AW + 1;
  localparam int SW  = $clog2(NUM_SETS);

  localparam logic [7:0] OP_CHAR    = 8'h00;
  localparam logic [7:0] OP_ANY     = 8'h01;
  localparam logic [7:0] OP_SET     = 8'h02;
  localparam logic [7:0] OP_TCHAR   = 8'h03;
  localparam logic [7:0] OP_TSET    = 8'h04;
  localparam logic [7:0] OP_CHOICE  = 8'h05;
  localparam logic [7:0] OP_COMMIT  = 8'h06;
  localparam logic [7:0] OP_PCOMMIT = 8'h07;
  localparam logic [7:0] OP_BCOMMIT = 8'h08;
  localparam logic [7:0] OP_JMP     = 8'h09;
  localparam logic [7:0] OP_FAIL    = 8'h0A;
  localparam logic [7:0] OP_FAIL2   = 8'h0B;
  localparam logic [7:0] OP_END     = 8'h0E;
`ifdef RPL_SPAN_EN
  localparam logic [7:0] OP_SPAN    = 8'h0C;
  localparam logic [7:0] OP_UNTIL   = 8'h0D;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_SCAN, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   len_q, len_d;
  logic [POS_W-1:0]   spos_q, spos_d;
  logic [SPW-1:0]     sp_q, sp_d;
  logic [SPW-1:0]     bt_max_q, bt_max_d;
  logic               matched_q, matched_d;
  logic [POS_W-1:0]   match_end_q, match_end_d;
  logic [1:0]         err_q, err_d;
  logic [255:0]       cs_q [NUM_SETS];
  logic [255:0]       cs_d [NUM_SETS];

  logic [PC_W-1:0]    bt_pc_q  [BT_DEPTH];
  logic [POS_W-1:0]   bt_pos_q [BT_DEPTH];
  logic               stk_we;
  logic [AW-1:0]      stk_waddr;
  logic [PC_W-1:0]    stk_wpc;
  logic [POS_W-1:0]   stk_wpos;

`ifdef RPL_SPAN_EN
  logic               scan_until_q, scan_until_d;
  logic [7:0]         scan_arg_q, scan_arg_d;
  logic               scan_rd_q, scan_rd_d;
  logic               scan_hit;
`endif

  logic [7:0]         op;
  logic [7:0]         arg;
  logic [PC_W-1:0]    off;
  logic [PC_W-1:0]    pc_inc, pc_rel;
  logic [POS_W-1:0]   pos_inc;
  logic               pos_ok, char_hit, set_hit;
  logic [SPW-1:0]     sp_m1, sp_m2, sp_p1;
  logic [AW-1:0]      top_idx, sec_idx;
  logic               stack_empty, stack_full;
  logic               do_fail, fail_two;

  // Decode fields of the instruction word and derive the common candidate values.
  assign op          = code_data[31:24];
  assign arg         = code_data[7:0];
  assign off         = PC_W'({{16{code_data[23]}}, code_data[23:8]});
  assign pc_inc      = pc_q + PC_W'(1);
  assign pc_rel      = pc_q + off;
  assign pos_inc     = pos_q + POS_W'(1);
  assign pos_ok      = pos_q < len_q;
  assign char_hit    = pos_ok && (in_data == arg);
  assign set_hit     = pos_ok && cs_q[arg[SW-1:0]][in_data];
  assign sp_m1       = sp_q - SPW'(1);
  assign sp_m2       = sp_q - SPW'(2);
  assign sp_p1       = sp_q + SPW'(1);
  assign top_idx     = AW'(sp_m1);
  assign sec_idx     = AW'(sp_m2);
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SPW'(BT_DEPTH));

`ifdef RPL_SPAN_EN
  assign scan_hit = pos_ok && (scan_until_q ? (in_data != scan_arg_q)
                                            : cs_q[scan_arg_q[SW-1:0]][in_data]);
`endif

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign matched   = matched_q;
  assign match_end = match_end_q;
  assign err       = err_q;
  assign bt_max    = bt_max_q;
  assign code_addr = pc_q;
  assign in_addr   = pos_q;

  // Charset loading is accepted only while idle, so a run never sees its table change.
  always_comb begin
    cs_d = cs_q;
    if (cs_we && !busy) begin
      cs_d[cs_sel][{cs_word, 5'd0} +: 32] = cs_wdata;
    end
  end

  // Next-state logic: run start, instruction execution, backtracking and the scan loop.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pos_d       = pos_q;
    len_d       = len_q;
    spos_d      = spos_q;
    sp_d        = sp_q;
    bt_max_d    = bt_max_q;
    matched_d   = matched_q;
    match_end_d = match_end_q;
    err_d       = err_q;
    stk_we      = 1'b0;
    stk_waddr   = AW'(sp_q);
    stk_wpc     = pc_rel;
    stk_wpos    = pos_q;
    do_fail     = 1'b0;
    fail_two    = 1'b0;
`ifdef RPL_SPAN_EN
    scan_until_d = scan_until_q;
    scan_arg_d   = scan_arg_q;
    scan_rd_d    = scan_rd_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d     = S_FETCH;
          pc_d        = start_pc;
          pos_d       = start_pos;
          len_d       = in_len;
          spos_d      = start_pos;
          sp_d        = '0;
          bt_max_d    = '0;
          matched_d   = 1'b0;
          match_end_d = start_pos;
          err_d       = 2'd0;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_CHAR, OP_ANY, OP_SET: begin
            if ((op == OP_CHAR && char_hit) || (op == OP_ANY && pos_ok) ||
                (op == OP_SET && set_hit)) begin
              pos_d = pos_inc;
              pc_d  = pc_inc;
            end else begin
              do_fail = 1'b1;
            end
          end
          OP_TCHAR: pc_d = char_hit ? pc_inc : pc_rel;
          OP_TSET:  pc_d = set_hit ? pc_inc : pc_rel;
          OP_CHOICE: begin
            if (stack_full) begin
              err_d   = 2'd1;
              state_d = S_DONE;
            end else begin
              stk_we = 1'b1;
              sp_d   = sp_p1;
              pc_d   = pc_inc;
              if (sp_p1 > bt_max_q) begin
                bt_max_d = sp_p1;
              end
            end
          end
          OP_COMMIT, OP_PCOMMIT, OP_BCOMMIT: begin
            if (stack_empty) begin
              err_d   = 2'd3;
              state_d = S_DONE;
            end else begin
              pc_d = pc_rel;
              if (op == OP_PCOMMIT) begin
                stk_we    = 1'b1;
                stk_waddr = top_idx;
                stk_wpc   = bt_pc_q[top_idx];
                stk_wpos  = pos_q;
              end else begin
                sp_d = sp_m1;
                if (op == OP_BCOMMIT) begin
                  pos_d = bt_pos_q[top_idx];
                end
              end
            end
          end
          OP_JMP:  pc_d = pc_rel;
          OP_FAIL: do_fail = 1'b1;
          OP_FAIL2: begin
            if (stack_empty) begin
              err_d   = 2'd3;
              state_d = S_DONE;
            end else begin
              do_fail  = 1'b1;
              fail_two = 1'b1;
            end
          end
`ifdef RPL_SPAN_EN
          OP_SPAN, OP_UNTIL: begin
            state_d      = S_SCAN;
            scan_until_d = (op == OP_UNTIL);
            scan_arg_d   = arg;
            scan_rd_d    = 1'b0;
          end
`endif
          OP_END: begin
            matched_d   = 1'b1;
            match_end_d = pos_q;
            state_d     = S_DONE;
          end
          default: begin
            err_d   = 2'd2;
            state_d = S_DONE;
          end
        endcase
        if (do_fail) begin
          if (fail_two) begin
            if (sp_q == SPW'(1)) begin
              state_d = S_DONE;
            end else begin
              pc_d  = bt_pc_q[sec_idx];
              pos_d = bt_pos_q[sec_idx];
              sp_d  = sp_m2;
            end
          end else if (stack_empty) begin
            state_d = S_DONE;
          end else begin
            pc_d  = bt_pc_q[top_idx];
            pos_d = bt_pos_q[top_idx];
            sp_d  = sp_m1;
          end
        end
      end
`ifdef RPL_SPAN_EN
      S_SCAN: begin
        if (!scan_rd_q) begin
          scan_rd_d = 1'b1;
        end else if (scan_hit) begin
          pos_d     = pos_inc;
          scan_rd_d = 1'b0;
        end else begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset returns the engine to an idle, empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      pos_q       <= '0;
      len_q       <= '0;
      spos_q      <= '0;
      sp_q        <= '0;
      bt_max_q    <= '0;
      matched_q   <= 1'b0;
      match_end_q <= '0;
      err_q       <= 2'd0;
      for (int i = 0; i < NUM_SETS; i++) begin
        cs_q[i] <= '0;
      end
`ifdef RPL_SPAN_EN
      scan_until_q <= 1'b0;
      scan_arg_q   <= '0;
      scan_rd_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      spos_q      <= spos_d;
      sp_q        <= sp_d;
      bt_max_q    <= bt_max_d;
      matched_q   <= matched_d;
      match_end_q <= match_end_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_SETS; i++) begin
        cs_q[i] <= cs_d[i];
      end
`ifdef RPL_SPAN_EN
      scan_until_q <= scan_until_d;
      scan_arg_q   <= scan_arg_d;
      scan_rd_q    <= scan_rd_d;
`endif
    end
  end

  // Backtrack stack storage; emptiness is tracked by sp_q, so the entries need no reset.
  always_ff @(posedge clk) begin
    if (stk_we) begin
      bt_pc_q[stk_waddr]  <= stk_wpc;
      bt_pos_q[stk_waddr] <= stk_wpos;
    end
  end

endmodule

// File: tb/tb_rpl_match_engine.sv
// tb_rpl_match_engine: self-checking bench for rpl_match_engine.
// The bench runs directed scenarios and randomized programs. It compares the DUT
// against a behavioural interpreter of the VM. Honours RPL_SPAN_EN like the RTL.
module tb_rpl_match_engine;

  localparam int PC_W     = 12;
  localparam int POS_W    = 16;
  localparam int BT_DEPTH = 4;
  localparam int NUM_SETS = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic [POS_W-1:0]  start_pos;
  logic [POS_W-1:0]  in_len;
  logic              busy;
  logic              done;
  logic              matched;
  logic [POS_W-1:0]  match_end;
  logic [1:0]        err;
  logic [2:0]        bt_max;
  logic [PC_W-1:0]   code_addr;
  logic [31:0]       code_data;
  logic [POS_W-1:0]  in_addr;
  logic [7:0]        in_data;
  logic              cs_we;
  logic [2:0]        cs_sel;
  logic [2:0]        cs_word;
  logic [31:0]       cs_wdata;

  rpl_match_engine #(
    .PC_W(PC_W), .POS_W(POS_W), .BT_DEPTH(BT_DEPTH), .NUM_SETS(NUM_SETS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .start_pos(start_pos), .in_len(in_len), .busy(busy), .done(done),
    .matched(matched), .match_end(match_end), .err(err), .bt_max(bt_max),
    .code_addr(code_addr), .code_data(code_data), .in_addr(in_addr),
    .in_data(in_data), .cs_we(cs_we), .cs_sel(cs_sel), .cs_word(cs_word),
    .cs_wdata(cs_wdata)
  );

  typedef struct packed { int pc; int pos; } bt_t;

  logic [31:0]  rom [0:4095];
  logic [7:0]   mem [0:65535];
  logic [255:0] csModel [0:7];
  int checkCount = 0;
  int errorCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous code ROM and input buffer.
  always @(posedge clk) begin
    code_data <= rom[code_addr];
    in_data   <= mem[in_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int off, input int arg);
    return {8'(op), 16'(off), 8'(arg)};
  endfunction

  task automatic clearRom();
    for (int i = 0; i < 4096; i++) rom[i] = mk(14, 0, 0);
  endtask

  task automatic loadInput(input int spos, input string s);
    for (int i = 0; i < s.len(); i++) mem[spos + i] = s[i];
  endtask

  task automatic writeCs(input int sel, input int word, input logic [31:0] data);
    cs_we = 1'b1; cs_sel = 3'(sel); cs_word = 3'(word); cs_wdata = data;
    csModel[sel][word*32 +: 32] = data;
    @(negedge clk);
    cs_we = 1'b0;
  endtask

  // Reference interpreter: runs the program from the VM rules and returns result and latency.
  function automatic void modelRun(input int spc, input int spos, input int len,
                                   output int m, output int me, output int e,
                                   output int bmax, output int lat);
    int pc, pos, off, op, arg, steps;
    logic [31:0] w;
    bit fin, doFail;
    bt_t t;
    bt_t stk[$];
    pc = spc; pos = spos; m = 0; me = spos; e = 0; bmax = 0; lat = 0;
    fin = 0; steps = 0;
    while (!fin && steps < 5000) begin
      steps++;
      w = rom[pc];
      op = int'(w[31:24]);
      off = int'($signed(w[23:8]));
      arg = int'(w[7:0]);
      lat += 2;
      doFail = 0;
      case (op)
        0: if (pos < len && mem[pos] == arg) begin pos++; pc++; end else doFail = 1;
        1: if (pos < len) begin pos++; pc++; end else doFail = 1;
        2: if (pos < len && csModel[arg % 8][mem[pos]]) begin pos++; pc++; end else doFail = 1;
        3: pc = (pos < len && mem[pos] == arg) ? pc + 1 : pc + off;
        4: pc = (pos < len && csModel[arg % 8][mem[pos]]) ? pc + 1 : pc + off;
        5: begin
          if (stk.size() == BT_DEPTH) begin e = 1; fin = 1; end
          else begin
            t.pc = (pc + off) & 4095; t.pos = pos;
            stk.push_back(t);
            if (stk.size() > bmax) bmax = stk.size();
            pc++;
          end
        end
        6, 7, 8: begin
          if (stk.size() == 0) begin e = 3; fin = 1; end
          else begin
            if (op == 7) stk[stk.size() - 1].pos = pos;
            else begin
              t = stk.pop_back();
              if (op == 8) pos = t.pos;
            end
            pc += off;
          end
        end
        9:  pc += off;
        10: doFail = 1;
        11: begin
          if (stk.size() == 0) begin e = 3; fin = 1; end
          else begin void'(stk.pop_back()); doFail = 1; end
        end
`ifdef RPL_SPAN_EN
        12, 13: begin
          while (pos < len && (op == 12 ? csModel[arg % 8][mem[pos]] == 1'b1 : mem[pos] != arg)) begin
            pos++; lat += 2;
          end
          lat += 2;
          pc++;
        end
`endif
        14: begin m = 1; me = pos; fin = 1; end
        default: begin e = 2; fin = 1; end
      endcase
      if (doFail) begin
        if (stk.size() == 0) fin = 1;
        else begin t = stk.pop_back(); pc = t.pc; pos = t.pos; end
      end
      pc = pc & 4095;
    end
  endfunction

  // Start one run, optionally with a same-cycle charset write, and check every result.
  task automatic applyStimulus(input string tag, input int spc, input int spos, input int len,
                               input int csSel, input int csWord, input logic [31:0] csData,
                               input int expM, input int expMe, input int expErr,
                               input int expBmax, input int expLat);
    int cnt;
    start_pc = PC_W'(spc); start_pos = POS_W'(spos); in_len = POS_W'(len); start = 1'b1;
    if (csSel >= 0) begin
      cs_we = 1'b1; cs_sel = 3'(csSel); cs_word = 3'(csWord); cs_wdata = csData;
      csModel[csSel][csWord*32 +: 32] = csData;
    end
    @(negedge clk);
    start = 1'b0; cs_we = 1'b0;
    checkOutput({tag, " busy"}, busy, 1);
    cnt = 0;
    while (!done && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " latency"}, cnt, expLat);
    checkOutput({tag, " busy_low"}, busy, 0);
    checkOutput({tag, " matched"}, matched, expM);
    checkOutput({tag, " match_end"}, match_end, expMe);
    checkOutput({tag, " err"}, err, expErr);
    checkOutput({tag, " bt_max"}, bt_max, expBmax);
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, done, 0);
    checkOutput({tag, " matched_hold"}, matched, expM);
  endtask

  initial begin
    int spc, spos, ilen, n, r, m, me, e, bm, lat;
    rst = 1'b1; start = 1'b0; start_pc = '0; start_pos = '0; in_len = '0;
    cs_we = 1'b0; cs_sel = '0; cs_word = '0; cs_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) csModel[i] = '0;
    clearRom();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset matched", matched, 0);
    checkOutput("reset match_end", match_end, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset bt_max", bt_max, 0);
    checkOutput("reset code_addr", code_addr, 0);
    checkOutput("reset in_addr", in_addr, 0);

    // Straight-line literal match.
    rom[16] = mk(0, 0, "a"); rom[17] = mk(0, 0, "b"); rom[18] = mk(0, 0, "c"); rom[19] = mk(14, 0, 0);
    loadInput(0, "abcd");
    applyStimulus("abc", 16, 0, 4, -1, 0, 0, 1, 3, 0, 0, 8);

    // Choice with a failing first alternative.
    rom[32] = mk(5, 3, 0); rom[33] = mk(0, 0, "x"); rom[34] = mk(6, 2, 0);
    rom[35] = mk(0, 0, "a"); rom[36] = mk(14, 0, 0);
    loadInput(0, "ab");
    applyStimulus("choice", 32, 0, 2, -1, 0, 0, 1, 1, 0, 1, 8);

    // Endless choice loop overflows the 4-entry stack.
    rom[48] = mk(5, 1, 0); rom[49] = mk(9, -1, 0);
    applyStimulus("overflow", 48, 0, 2, -1, 0, 0, 0, 0, 1, 4, 18);

    // Digit span, with the charset word written in the same cycle as start.
    rom[64] = mk(12, 0, 0); rom[65] = mk(14, 0, 0);
    loadInput(200, "123x");
`ifdef RPL_SPAN_EN
    applyStimulus("span", 64, 200, 204, 0, 1, 32'h03FF0000, 1, 203, 0, 0, 12);
`else
    applyStimulus("span", 64, 200, 204, 0, 1, 32'h03FF0000, 0, 200, 2, 0, 2);
`endif

    // Plain mismatch, commit on empty stack, and a byte that matches but lies at len.
    rom[80] = mk(0, 0, "z");
    loadInput(0, "a");
    applyStimulus("nomatch", 80, 0, 1, -1, 0, 0, 0, 0, 0, 0, 2);
    rom[90] = mk(6, 2, 0);
    applyStimulus("commit_empty", 90, 5, 9, -1, 0, 0, 0, 5, 3, 0, 2);
    rom[120] = mk(0, 0, "a");
    loadInput(10, "a");
    applyStimulus("at_len", 120, 10, 10, -1, 0, 0, 0, 10, 0, 0, 2);

    // Randomized programs against the interpreter.
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 8; w++) writeCs(s, w, $urandom);
    for (int iter = 0; iter < 40; iter++) begin
      clearRom();
      spc = $urandom_range(0, 4000);
      n = $urandom_range(3, 9);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 99);
        if (r < 15)      rom[spc + k] = mk(0, 0, $urandom_range(97, 99));
        else if (r < 22) rom[spc + k] = mk(1, 0, 0);
        else if (r < 32) rom[spc + k] = mk(2, 0, $urandom_range(0, 7));
        else if (r < 39) rom[spc + k] = mk(3, $urandom_range(1, 3), $urandom_range(97, 99));
        else if (r < 46) rom[spc + k] = mk(4, $urandom_range(1, 3), $urandom_range(0, 7));
        else if (r < 58) rom[spc + k] = mk(5, $urandom_range(1, 3), 0);
        else if (r < 64) rom[spc + k] = mk(6, $urandom_range(1, 3), 0);
        else if (r < 69) rom[spc + k] = mk(7, $urandom_range(1, 3), 0);
        else if (r < 74) rom[spc + k] = mk(8, $urandom_range(1, 3), 0);
        else if (r < 78) rom[spc + k] = mk(9, $urandom_range(1, 3), 0);
        else if (r < 81) rom[spc + k] = mk(10, 0, 0);
        else if (r < 85) rom[spc + k] = mk(11, 0, 0);
        else if (r < 89) rom[spc + k] = mk(12, 0, $urandom_range(0, 7));
        else if (r < 93) rom[spc + k] = mk(13, 0, $urandom_range(97, 99));
        else if (r < 97) rom[spc + k] = mk(14, 0, 0);
        else             rom[spc + k] = mk($urandom_range(15, 255), 0, 0);
      end
      spos = $urandom_range(0, 1000);
      ilen = $urandom_range(0, 8);
      for (int i = 0; i < ilen + 2; i++) mem[spos + i] = 8'($urandom_range(97, 99));
      modelRun(spc, spos, spos + ilen, m, me, e, bm, lat);
      applyStimulus($sformatf("rand%0d", iter), spc, spos, spos + ilen, -1, 0, 0, m, me, e, bm, lat);
    end

    // Reset in the middle of a long run (inside SCAN when the scan feature is built).
    clearRom();
    rom[100] = mk(5, 3, 0);
`ifdef RPL_SPAN_EN
    rom[101] = mk(12, 0, 0);
    rom[102] = mk(14, 0, 0);
    writeCs(0, 1, 32'h03FF0000);
`else
    for (int i = 0; i < 20; i++) rom[101 + i] = mk(0, 0, "1");
`endif
    for (int i = 0; i < 30; i++) mem[300 + i] = "1";
    start_pc = 12'd100; start_pos = 16'd300; in_len = 16'd330; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("midrun busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst matched", matched, 0);
    checkOutput("rst match_end", match_end, 0);
    checkOutput("rst err", err, 0);
    checkOutput("rst bt_max", bt_max, 0);
    checkOutput("rst code_addr", code_addr, 0);
    checkOutput("rst in_addr", in_addr, 0);
    for (int i = 0; i < 8; i++) csModel[i] = '0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst no_done", done, 0);
    end
    rom[16] = mk(0, 0, "a"); rom[17] = mk(0, 0, "b"); rom[18] = mk(0, 0, "c"); rom[19] = mk(14, 0, 0);
    loadInput(0, "abcd");
    applyStimulus("abc_after_rst", 16, 0, 4, -1, 0, 0, 1, 3, 0, 0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
